// File: rtl/rf_op_sequencer.sv
// Multi-cycle command sequencer for the 8-entry T1-T4/R1-R4 register file; owns all RF write enables.
// Optional feature: define RF_SEQ_ABORT_EN to add the Abort input (cancel a running command with Err).
module rf_op_sequencer #(
    parameter int CNT_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic              Clock,
    input  logic              Reset,
`ifdef RF_SEQ_ABORT_EN
    input  logic              Abort,
`endif
    input  logic              CmdValid,
    output logic              CmdReady,
    input  logic [2:0]        Op,
    input  logic [2:0]        Dst,
    input  logic [2:0]        Src,
    input  logic [CNT_W-1:0]  Count,
    input  logic [DATA_W-1:0] ImmData,
    output logic [DATA_W-1:0] ImmHold,
    output logic              InSel,
    output logic [1:0]        FunSel,
    output logic [3:0]        RSel,
    output logic [3:0]        TSel,
    output logic [2:0]        O1Sel,
    output logic [2:0]        O2Sel,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);
    typedef enum logic [2:0] {S_IDLE, S_WR, S_REP, S_SW1, S_SW2, S_SW3, S_DONE} state_t;

    localparam logic [2:0] OP_CLR = 3'd0, OP_LDI = 3'd1, OP_INC = 3'd2,
                           OP_DEC = 3'd3, OP_MOV = 3'd4, OP_SWAP = 3'd5;
    localparam logic [1:0] FUN_CLR = 2'b00, FUN_LOAD = 2'b01, FUN_DEC = 2'b10, FUN_INC = 2'b11;
    localparam logic [2:0] IDX_T4 = 3'd3;

    state_t             state;
    logic [2:0]         dst_q, src_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [7:0]         wen_q;
    logic [1:0]         fun_q;
    logic               insel_q, done_q, err_q;
    logic [2:0]         o1_q, o2_q;
    logic [DATA_W-1:0]  imm_q;
    logic               abort_act;

    // Index coding matches the enable layout: bits 0-3 are T1-T4, bits 4-7 are R1-R4.
    function automatic logic [7:0] onehot(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

`ifdef RF_SEQ_ABORT_EN
    assign abort_act = Abort && (state != S_IDLE) && (state != S_DONE);
`else
    assign abort_act = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= S_IDLE;
            dst_q   <= '0;
            src_q   <= '0;
            cnt_q   <= '0;
            wen_q   <= '0;
            fun_q   <= FUN_CLR;
            insel_q <= 1'b0;
            o1_q    <= '0;
            o2_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                S_IDLE: if (CmdValid) begin
                    dst_q   <= Dst;
                    src_q   <= Src;
                    o2_q    <= Dst;
                    o1_q    <= '0;
                    insel_q <= 1'b0;
                    wen_q   <= '0;
                    fun_q   <= FUN_LOAD;
                    case (Op)
                        OP_CLR: begin
                            state <= S_WR;
                            wen_q <= onehot(Dst);
                            fun_q <= FUN_CLR;
                        end
                        OP_LDI: begin
                            state <= S_WR;
                            wen_q <= onehot(Dst);
                        end
                        OP_INC, OP_DEC: begin
                            state <= S_REP;
                            wen_q <= onehot(Dst);
                            fun_q <= (Op == OP_INC) ? FUN_INC : FUN_DEC;
                            // cnt_q holds the REP cycles still to come after the first one
                            cnt_q <= (Count == '0) ? '0 : Count - 1'b1;
                        end
                        OP_MOV: begin
                            if (Dst == Src) begin
                                state  <= S_DONE;
                                done_q <= 1'b1;
                            end else begin
                                state   <= S_WR;
                                wen_q   <= onehot(Dst);
                                insel_q <= 1'b1;
                                o1_q    <= Src;
                            end
                        end
                        OP_SWAP: begin
                            if (Dst == IDX_T4 || Src == IDX_T4) begin
                                state  <= S_DONE;
                                done_q <= 1'b1;
                                err_q  <= 1'b1;
                            end else if (Dst == Src) begin
                                state  <= S_DONE;
                                done_q <= 1'b1;
                            end else begin
                                state   <= S_SW1;
                                wen_q   <= onehot(IDX_T4);
                                insel_q <= 1'b1;
                                o1_q    <= Dst;
                            end
                        end
                        default: begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end
                    endcase
                end
                S_REP: begin
                    if (cnt_q == '0) begin
                        state  <= S_DONE;
                        wen_q  <= '0;
                        done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_SW1: begin
                    state <= S_SW2;
                    wen_q <= onehot(dst_q);
                    o1_q  <= src_q;
                end
                S_SW2: begin
                    state <= S_SW3;
                    wen_q <= onehot(src_q);
                    o1_q  <= IDX_T4;
                end
                S_WR, S_SW3: begin
                    state  <= S_DONE;
                    wen_q  <= '0;
                    done_q <= 1'b1;
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    fun_q   <= FUN_CLR;
                    insel_q <= 1'b0;
                    o1_q    <= '0;
                end
                default: state <= S_IDLE;
            endcase
            if (abort_act) begin
                state  <= S_DONE;
                wen_q  <= '0;
                done_q <= 1'b1;
                err_q  <= 1'b1;
            end
        end
    end

    // Immediate is data, not control: captured at accept so LDI sees it during the WR cycle.
    always_ff @(posedge Clock) begin
        if (state == S_IDLE && CmdValid)
            imm_q <= ImmData;
    end

    assign {RSel, TSel} = wen_q & ~{8{abort_act}};
    assign CmdReady     = (state == S_IDLE);
    assign Busy         = (state != S_IDLE);
    assign Done         = done_q;
    assign Err          = err_q;
    assign FunSel       = fun_q;
    assign InSel        = insel_q;
    assign O1Sel        = o1_q;
    assign O2Sel        = o2_q;
    assign ImmHold      = imm_q;
endmodule

// File: tb/tb_rf_op_sequencer.sv
// Randomized bench for rf_op_sequencer: a behavioural register file follows the DUT's controls
// and a command-level reference model predicts writes, latency, Err and final register contents.
module tb_rf_op_sequencer;
    localparam int CNT_W  = 4;
    localparam int DATA_W = 8;

    logic              Clock = 1'b0;
    logic              Reset;
    logic              CmdValid;
    logic              CmdReady;
    logic [2:0]        Op, Dst, Src;
    logic [CNT_W-1:0]  Count;
    logic [DATA_W-1:0] ImmData, ImmHold;
    logic              InSel;
    logic [1:0]        FunSel;
    logic [3:0]        RSel, TSel;
    logic [2:0]        O1Sel, O2Sel;
    logic              Busy, Done, Err;
`ifdef RF_SEQ_ABORT_EN
    logic              Abort = 1'b0;
`endif

    rf_op_sequencer #(.CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
        .Clock(Clock), .Reset(Reset),
`ifdef RF_SEQ_ABORT_EN
        .Abort(Abort),
`endif
        .CmdValid(CmdValid), .CmdReady(CmdReady), .Op(Op), .Dst(Dst), .Src(Src),
        .Count(Count), .ImmData(ImmData), .ImmHold(ImmHold), .InSel(InSel),
        .FunSel(FunSel), .RSel(RSel), .TSel(TSel), .O1Sel(O1Sel), .O2Sel(O2Sel),
        .Busy(Busy), .Done(Done), .Err(Err)
    );

    always #5 Clock = ~Clock;

    // Behavioural register file driven by the sequencer outputs
    logic [7:0] rf [8];
    logic [7:0] en;
    logic [7:0] rf_in;
    assign en    = {RSel, TSel};
    assign rf_in = InSel ? rf[O1Sel] : ImmHold;

    always_ff @(posedge Clock) begin
        for (int i = 0; i < 8; i++) begin
            if (en[i]) begin
                case (FunSel)
                    2'b00:   rf[i] <= 8'h00;
                    2'b01:   rf[i] <= rf_in;
                    2'b10:   rf[i] <= rf[i] - 8'd1;
                    default: rf[i] <= rf[i] + 8'd1;
                endcase
            end
        end
    end

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [7:0]  ref_rf [8];
    logic [13:0] exp_q[$];
    logic [13:0] obs_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [13:0] ent(input logic [2:0] idx, input logic [1:0] fun,
                                        input logic insel, input logic [2:0] o1);
        logic [7:0] e;
        e = 8'd1 << idx;
        return {e, fun, insel, insel ? o1 : 3'd0};
    endfunction

    // Command-level model: expected write sequence, final RF state, error and abort outcome
    task automatic model(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s,
                         input logic [3:0] c, input logic [7:0] imm, input int abort_at,
                         output bit e, output bit ab);
        int n;
        logic [7:0] t;
        exp_q.delete();
        e  = 1'b0;
        ab = 1'b0;
        case (op)
            3'd0: begin ref_rf[d] = 8'h00; exp_q.push_back(ent(d, 2'b00, 1'b0, 3'd0)); end
            3'd1: begin ref_rf[d] = imm;   exp_q.push_back(ent(d, 2'b01, 1'b0, 3'd0)); end
            3'd2, 3'd3: begin
                n = (c == 0) ? 1 : int'(c);
                if (abort_at > 0 && abort_at <= n) begin
                    n  = abort_at - 1;
                    ab = 1'b1;
                end
                for (int i = 0; i < n; i++)
                    exp_q.push_back(ent(d, (op == 3'd2) ? 2'b11 : 2'b10, 1'b0, 3'd0));
                ref_rf[d] = (op == 3'd2) ? ref_rf[d] + 8'(n) : ref_rf[d] - 8'(n);
            end
            3'd4: if (d != s) begin
                ref_rf[d] = ref_rf[s];
                exp_q.push_back(ent(d, 2'b01, 1'b1, s));
            end
            3'd5: begin
                if (d == 3'd3 || s == 3'd3) e = 1'b1;
                else if (d != s) begin
                    exp_q.push_back(ent(3'd3, 2'b01, 1'b1, d));
                    exp_q.push_back(ent(d, 2'b01, 1'b1, s));
                    exp_q.push_back(ent(s, 2'b01, 1'b1, 3'd3));
                    t = ref_rf[d];
                    ref_rf[d] = ref_rf[s];
                    ref_rf[s] = t;
                    ref_rf[3] = t;
                end
            end
            default: e = 1'b1;
        endcase
    endtask

    task automatic run(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s,
                       input logic [3:0] c, input logic [7:0] imm, input int abort_at,
                       input string tag);
        bit e, ab, seen, errv;
        int k, kd, wc;
        model(op, d, s, c, imm, abort_at, e, ab);
        wc = 0;
        while (!CmdReady && wc < 20) begin
            @(negedge Clock); #1; wc++;
        end
        chk({tag, ".ready"}, CmdReady, 1);
        CmdValid = 1'b1; Op = op; Dst = d; Src = s; Count = c; ImmData = imm;
        @(posedge Clock); #1;
        CmdValid = 1'b0;
        Op = 3'($urandom); Dst = 3'($urandom); Src = 3'($urandom);
        Count = 4'($urandom); ImmData = 8'($urandom);
        obs_q.delete();
        k = 0; kd = -1; seen = 1'b0; errv = 1'b0;
        while (!seen && k < 40) begin
            @(negedge Clock); k++;
`ifdef RF_SEQ_ABORT_EN
            if (k == abort_at) Abort = 1'b1;
`endif
            #1;
            if (k == 1) begin
                chk({tag, ".busy"}, {Busy, CmdReady}, 2'b10);
            end
            if (en != 8'h00) obs_q.push_back({en, FunSel, InSel, InSel ? O1Sel : 3'd0});
            if (Done) begin
                seen = 1'b1; kd = k; errv = Err;
            end
            @(posedge Clock); #1;
`ifdef RF_SEQ_ABORT_EN
            Abort = 1'b0;
`endif
        end
        chk({tag, ".latency"}, kd, exp_q.size() + 1 + (ab ? 1 : 0));
        chk({tag, ".err"}, errv, e | ab);
        chk({tag, ".nwrites"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk({tag, ".write"}, obs_q[i], exp_q[i]);
        for (int i = 0; i < 8; i++)
            chk({tag, ".rf"}, {i[3:0], rf[i]}, {i[3:0], ref_rf[i]});
        chk({tag, ".idle"}, {Done, CmdReady}, 2'b01);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        bit [2:0] op, d, s;
        bit [3:0] c;
        int ab_at;
        Reset = 1'b1; CmdValid = 1'b0; Op = '0; Dst = '0; Src = '0; Count = '0; ImmData = '0;
        #1;
        chk("rst.ctl", {CmdReady, Busy, Done, Err, InSel, FunSel}, 7'b1000000);
        chk("rst.en", {RSel, TSel}, 8'h00);
        chk("rst.osel", {O1Sel, O2Sel}, 6'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;

        for (int i = 0; i < 8; i++) run(3'd1, 3'(i), 3'd0, 4'd0, 8'($urandom), 0, "pre");

        run(3'd1, 3'd4, 3'd0, 4'd0, 8'hA5, 0, "ldi");
        chk("ldi.R1", rf[4], 8'hA5);
        chk("ldi.ctl", obs_q[0], {8'b0001_0000, 2'b01, 1'b0, 3'd0});

        run(3'd1, 3'd1, 3'd0, 4'd0, 8'hFE, 0, "ldT2");
        run(3'd2, 3'd1, 3'd0, 4'd3, 8'h00, 0, "inc3");
        chk("inc3.T2", rf[1], 8'h01);

        run(3'd1, 3'd5, 3'd0, 4'd0, 8'h11, 0, "ldR2");
        run(3'd1, 3'd6, 3'd0, 4'd0, 8'h22, 0, "ldR3");
        run(3'd5, 3'd5, 3'd6, 4'd0, 8'h00, 0, "swap");
        chk("swap.regs", {rf[5], rf[6], rf[3]}, 24'h221111);

        run(3'd5, 3'd2, 3'd3, 4'd0, 8'h00, 0, "swapT4");
        run(3'd7, 3'd0, 3'd1, 4'd0, 8'h00, 0, "illegal");
        run(3'd6, 3'd2, 3'd1, 4'd0, 8'h00, 0, "illegal6");
        run(3'd2, 3'd0, 3'd0, 4'd0, 8'h00, 0, "inc0");
        run(3'd3, 3'd7, 3'd0, 4'd15, 8'h00, 0, "dec15");
        run(3'd4, 3'd2, 3'd2, 4'd0, 8'h00, 0, "movsame");
        run(3'd5, 3'd6, 3'd6, 4'd0, 8'h00, 0, "swapsame");
        run(3'd4, 3'd7, 3'd0, 4'd0, 8'h00, 0, "mov");
        run(3'd0, 3'd5, 3'd0, 4'd0, 8'h00, 0, "clr");

`ifdef RF_SEQ_ABORT_EN
        run(3'd1, 3'd0, 3'd0, 4'd0, 8'h10, 0, "ldT1");
        run(3'd2, 3'd0, 3'd0, 4'd10, 8'h00, 4, "abort");
        chk("abort.T1", rf[0], 8'h13);
`endif

        for (int n = 0; n < 60; n++) begin
            op = 3'($urandom_range(0, 7));
            d  = 3'($urandom); s = 3'($urandom); c = 4'($urandom);
            ab_at = 0;
`ifdef RF_SEQ_ABORT_EN
            if ((op == 3'd2 || op == 3'd3) && $urandom_range(0, 2) == 0)
                ab_at = $urandom_range(1, ((c == 0) ? 1 : int'(c)) + 1);
`endif
            run(op, d, s, c, 8'($urandom), ab_at, "rand");
        end

        // Reset in the middle of an INC: enables drop at once, the writes already made remain
        CmdValid = 1'b1; Op = 3'd2; Dst = 3'd7; Count = 4'd15;
        @(posedge Clock); #1;
        CmdValid = 1'b0;
        repeat (3) @(posedge Clock);
        ref_rf[7] = ref_rf[7] + 8'd3;
        #4 Reset = 1'b1;
        #1;
        chk("midrst.en", {RSel, TSel}, 8'h00);
        chk("midrst.ctl", {CmdReady, Busy, Done}, 3'b100);
        @(negedge Clock);
        Reset = 1'b0;
        chk("midrst.R4", rf[7], ref_rf[7]);
        run(3'd1, 3'd7, 3'd0, 4'd0, 8'h5A, 0, "postrst");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
